// File: rtl/fifo_pkt_writer_pkg.sv
// Shared types and framing constants for the dual-clock FIFO packet writer.
// Trailer layout: truncate flag in the MSB, payload length in the bits below it.
package fifo_pkt_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        DROP,
        TRL,
        SETTLE
    } state_t;

    localparam int SETTLE_CYCLES  = 2;
    localparam int FRAME_OVERHEAD = 2;

    function automatic int trl_trunc_bit(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int trl_len_msb(input int data_w);
        return data_w - 2;
    endfunction

endpackage

// File: rtl/fifo_pkt_writer.sv
// Frames an upstream valid/ready stream into the write side of a dual-clock FIFO
// as header (sequence), payload, trailer (length + truncate flag).
module fifo_pkt_writer
    import fifo_pkt_writer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 512,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH),
    parameter int MAX_PKT    = 64
) (
    input  logic              wrclk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              wrreq,
    output logic [DATA_W-1:0] wrdin,
    input  logic              wrfull,
    input  logic [ADDR_W-1:0] wrusedw,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic              busy
);

    localparam int TRL_TRUNC_BIT = trl_trunc_bit(DATA_W);
    localparam int TRL_LEN_MSB   = trl_len_msb(DATA_W);

    localparam logic [ADDR_W:0]   DEPTH_FULL  = (ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   ROOM_MIN    = (ADDR_W+1)'(MAX_PKT + FRAME_OVERHEAD);
    localparam logic [DATA_W-1:0] MAX_LEN     = DATA_W'(MAX_PKT);
    localparam logic [1:0]        SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [DATA_W-1:0] seq;
    logic [DATA_W-1:0] len;
    logic              trunc;
    logic [1:0]        settle_cnt;
    logic [ADDR_W:0]   free_words;
    logic              room;

    // wrusedw wraps to 0 when the FIFO is full, so wrfull must override it.
    always_comb begin
        free_words = '0;
        if (!wrfull) begin
            free_words = DEPTH_FULL - {1'b0, wrusedw};
        end
    end

    assign room = (free_words >= ROOM_MIN);
    assign busy = (state != IDLE);

    always_comb begin
        s_ready = 1'b0;
        wrreq   = 1'b0;
        wrdin   = '0;
        case (state)
            HDR: begin
                wrreq = ~wrfull;
                wrdin = seq;
            end
            PAY: begin
                s_ready = ~wrfull;
                wrreq   = s_valid & ~wrfull;
                wrdin   = s_data;
            end
            DROP: begin
                s_ready = 1'b1;
            end
            TRL: begin
                wrreq                  = ~wrfull;
                wrdin[TRL_TRUNC_BIT]   = trunc;
                wrdin[TRL_LEN_MSB:0]   = len[TRL_LEN_MSB:0];
            end
            default: begin
            end
        endcase
    end

    // SETTLE gives the FIFO's registered wrusedw time to catch up before the next admission check.
    always_ff @(posedge wrclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            seq        <= '0;
            len        <= '0;
            trunc      <= 1'b0;
            settle_cnt <= '0;
            pkt_done   <= 1'b0;
            pkt_err    <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid && room) begin
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (wrreq) begin
                        len   <= '0;
                        trunc <= 1'b0;
                        state <= PAY;
                    end
                end
                PAY: begin
                    if (s_valid && s_ready) begin
                        len <= len + 1'b1;
                        if (s_last) begin
                            state <= TRL;
                        end else if ((len + 1'b1) == MAX_LEN) begin
                            trunc <= 1'b1;
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (s_valid && s_last) begin
                        state <= TRL;
                    end
                end
                TRL: begin
                    if (wrreq) begin
                        pkt_done   <= 1'b1;
                        pkt_err    <= trunc;
                        seq        <= seq + 1'b1;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Self-checking bench for fifo_pkt_writer: directed cases plus randomized packets,
// with expected FIFO contents built from the framing rules as a word queue.
module tb_fifo_pkt_writer;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 512;
    localparam int ADDR_W     = 9;
    localparam int MAX_PKT    = 64;

    localparam int K_HDR = 0;
    localparam int K_PAY = 1;
    localparam int K_TRL = 2;

    typedef struct {
        logic [7:0] data;
        int         kind;
        logic       err;
    } exp_t;

    logic              wrclk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              wrreq;
    logic [DATA_W-1:0] wrdin;
    logic              wrfull;
    logic [ADDR_W-1:0] wrusedw;
    logic              pkt_done;
    logic              pkt_err;
    logic              busy;

    logic force_full = 1'b0;
    logic rnd_full   = 1'b0;
    logic stall_en   = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int wr_count    = 0;
    int first_pay_cyc = 0;
    int start_cyc   = 0;

    exp_t       exp_q[$];
    logic [7:0] pkt_data[$];
    logic [7:0] seq_m;
    exp_t       mon_e;
    logic       exp_done = 1'b0;
    logic       exp_err  = 1'b0;
    logic       after_hdr = 1'b0;

    assign wrfull = force_full | rnd_full;

    fifo_pkt_writer #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_W    (ADDR_W),
        .MAX_PKT   (MAX_PKT)
    ) dut (
        .wrclk   (wrclk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .wrreq   (wrreq),
        .wrdin   (wrdin),
        .wrfull  (wrfull),
        .wrusedw (wrusedw),
        .pkt_done(pkt_done),
        .pkt_err (pkt_err),
        .busy    (busy)
    );

    always #5 wrclk = ~wrclk;

    always @(posedge wrclk) cyc++;

    always @(posedge wrclk) begin
        #1;
        rnd_full = stall_en && ($urandom_range(0, 9) == 0);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Outputs are sampled mid-cycle; a word shown with wrreq here is written at the next rising edge.
    always @(negedge wrclk) begin
        if (!rst_n) begin
            checkOutput("reset_outs", 32'({s_ready, wrreq, pkt_done, pkt_err, busy}), 32'd0);
            exp_done  = 1'b0;
            exp_err   = 1'b0;
            after_hdr = 1'b0;
        end else begin
            checkOutput("pkt_done", 32'(pkt_done), 32'(exp_done));
            checkOutput("pkt_err", 32'(pkt_err), 32'(exp_err));
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (wrfull) checkOutput("wr_when_full", 32'(wrreq), 32'd0);
            if (wrreq) begin
                checkOutput("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    wr_count++;
                    case (mon_e.kind)
                        K_HDR:   checkOutput("hdr_word", 32'(wrdin), 32'(mon_e.data));
                        K_PAY:   checkOutput("pay_word", 32'(wrdin), 32'(mon_e.data));
                        default: checkOutput("trl_word", 32'(wrdin), 32'(mon_e.data));
                    endcase
                    if (mon_e.kind == K_TRL) begin
                        exp_done = 1'b1;
                        exp_err  = mon_e.err;
                    end
                    if (mon_e.kind == K_PAY && after_hdr) first_pay_cyc = cyc;
                    after_hdr = (mon_e.kind == K_HDR);
                end
            end
        end
    end

    task automatic fillPacket(input int n);
        pkt_data.delete();
        for (int i = 0; i < n; i++) pkt_data.push_back(8'($urandom));
    endtask

    // cut > 0 sends only that many non-final beats and expects no trailer (used before a reset).
    task automatic applyStimulus(input int cut, input bit gaps);
        int n, nw, nb, w;
        bit acc, trunc;
        n  = pkt_data.size();
        nw = (cut > 0) ? cut : ((n < MAX_PKT) ? n : MAX_PKT);
        nb = (cut > 0) ? cut : n;
        exp_q.push_back('{data: seq_m, kind: K_HDR, err: 1'b0});
        for (int i = 0; i < nw; i++) exp_q.push_back('{data: pkt_data[i], kind: K_PAY, err: 1'b0});
        if (cut == 0) begin
            trunc = (n > MAX_PKT);
            exp_q.push_back('{data: {trunc, 7'(nw)}, kind: K_TRL, err: trunc});
            seq_m = seq_m + 8'd1;
        end
        for (int i = 0; i < nb; i++) begin
            s_valid = 1'b1;
            s_data  = pkt_data[i];
            s_last  = (cut == 0) && (i == n - 1);
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 300) begin
                @(negedge wrclk);
                acc = s_ready;
                @(posedge wrclk);
                #1;
                w++;
            end
            checkOutput("beat_accept", 32'(acc), 32'd1);
            if (!acc) break;
            if (gaps && i != nb - 1 && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge wrclk);
                    #1;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic waitDrain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            @(posedge wrclk);
            #1;
            w++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        repeat (4) begin
            @(posedge wrclk);
            #1;
        end
    endtask

    task automatic expectIdle(input string tag, input int n);
        repeat (n) begin
            @(negedge wrclk);
            checkOutput(tag, 32'({s_ready, wrreq, busy}), 32'd0);
            @(posedge wrclk);
            #1;
        end
    endtask

    initial begin
        int base;
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hA1;
        s_last  = 1'b0;
        wrusedw = '0;
        seq_m   = 8'h00;
        repeat (3) @(posedge wrclk);
        #1;

        pkt_data  = {8'hA1, 8'hA2, 8'hA3};
        rst_n     = 1'b1;
        start_cyc = cyc;
        applyStimulus(0, 1'b0);
        waitDrain();
        checkOutput("first_pay_latency",
                    32'((first_pay_cyc - start_cyc) >= 2 && (first_pay_cyc - start_cyc) <= 3), 32'd1);

        fillPacket(4);
        applyStimulus(0, 1'b1);
        waitDrain();

        // Admission: hold a beat while free space is below one maximum frame.
        s_valid = 1'b1;
        s_data  = 8'h5A;
        wrusedw = 9'd500;
        expectIdle("adm_500", 6);
        wrusedw = 9'd447;
        expectIdle("adm_447", 6);
        wrusedw    = 9'd0;
        force_full = 1'b1;
        expectIdle("adm_full", 6);
        force_full = 1'b0;
        wrusedw    = 9'd446;
        fillPacket(2);
        applyStimulus(0, 1'b0);
        waitDrain();
        wrusedw = 9'd440;
        fillPacket(3);
        applyStimulus(0, 1'b0);
        waitDrain();
        wrusedw = 9'd0;

        fillPacket(70);
        applyStimulus(0, 1'b0);
        waitDrain();

        fillPacket(64);
        applyStimulus(0, 1'b0);
        waitDrain();

        fillPacket(10);
        base = wr_count;
        fork
            applyStimulus(0, 1'b0);
            begin
                int sw;
                sw = 0;
                while (wr_count < base + 4 && sw < 200) begin
                    @(posedge wrclk);
                    #1;
                    sw++;
                end
                force_full = 1'b1;
                repeat (3) begin
                    @(negedge wrclk);
                    checkOutput("stall_ready", 32'(s_ready), 32'd0);
                    checkOutput("stall_wrreq", 32'(wrreq), 32'd0);
                    @(posedge wrclk);
                    #1;
                end
                force_full = 1'b0;
            end
        join
        waitDrain();

        // Reset in the middle of a payload abandons the frame and restarts sequencing.
        fillPacket(20);
        applyStimulus(5, 1'b0);
        rst_n = 1'b0;
        @(negedge wrclk);
        checkOutput("rst_wrreq", 32'(wrreq), 32'd0);
        checkOutput("rst_flush", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        seq_m = 8'h00;
        repeat (2) @(posedge wrclk);
        #1;
        rst_n = 1'b1;
        @(negedge wrclk);
        checkOutput("busy_after_rst", 32'(busy), 32'd0);
        @(posedge wrclk);
        #1;
        fillPacket(3);
        applyStimulus(0, 1'b0);
        waitDrain();

        stall_en = 1'b1;
        for (int p = 0; p < 25; p++) begin
            wrusedw = 9'($urandom_range(0, 446));
            fillPacket($urandom_range(1, 80));
            applyStimulus(0, 1'b1);
            waitDrain();
        end
        stall_en = 1'b0;
        repeat (3) @(posedge wrclk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_writer.md
Name: fifo_pkt_writer

Overview:
- Write-side producer for the team's dual-clock FIFO. Lives entirely in the wrclk domain.
- Accepts an upstream valid/ready stream with frame markers and frames each packet into the FIFO as: header (sequence number), payload, trailer (length plus truncate flag).
- Admits a packet only when the FIFO is guaranteed to have room for a maximum-size frame. Never issues a write while the FIFO reports full.

Parameters:
- DATA_W, 8, width of FIFO word and stream data.
- FIFO_DEPTH, 512, depth of the attached FIFO (power of 2).
- ADDR_W, log2(FIFO_DEPTH), width of the wrusedw input.
- MAX_PKT, 64, maximum payload words per packet. Must satisfy 1 <= MAX_PKT <= 2^(DATA_W-1)-1.

Ports:
- wrclk  in  1  write-domain clock.
- rst_n  in  1  asynchronous reset, active-low.
- s_valid  in  1  upstream beat valid.
- s_data  in  DATA_W  upstream beat data.
- s_last  in  1  final beat of the packet.
- s_ready  out  1  beat accepted when s_valid & s_ready.
- wrreq  out  1  FIFO write request.
- wrdin  out  DATA_W  FIFO write data.
- wrfull  in  1  FIFO write-side full flag.
- wrusedw  in  ADDR_W  FIFO write-side used count. Registered in the FIFO; wraps to 0 when full.
- pkt_done  out  1  one-cycle pulse when the trailer is written.
- pkt_err  out  1  one-cycle pulse, coincident with pkt_done, when the packet was truncated.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; seq = 0; len = 0; trunc = 0; settle counter = 0.
  - Outputs: s_ready = 0, wrreq = 0, pkt_done = 0, pkt_err = 0, busy = 0.
  - Reset mid-packet abandons the frame. No further wrreq after reset assertion.
- Free-space calculation:
  - free = wrfull ? 0 : FIFO_DEPTH - wrusedw, computed at ADDR_W+1 bits.
  - room = (free >= MAX_PKT+2).
  - wrusedw==0 with wrfull==1 means full, not empty.
- wrreq/wrdin/s_ready are combinational from state and inputs. The FIFO samples them on the wrclk edge.
- Hard rule: wrreq is never 1 while wrfull is 1, in any state. The FIFO memory writes on wrreq regardless of full.
- State machine: IDLE, HDR, PAY, DROP, TRL, SETTLE.
  - IDLE: s_ready=0, wrreq=0. If s_valid & room, go to HDR. s_valid is held; that beat is not consumed here.
  - HDR: wrreq=~wrfull, wrdin=seq. On a write, go to PAY with len=0 and trunc=0.
  - PAY: s_ready=~wrfull, wrreq=s_valid&~wrfull, wrdin=s_data.
    - On an accepted beat, len++.
    - If s_last, go to TRL.
    - Else if len+1==MAX_PKT, go to DROP with trunc=1.
  - DROP: s_ready=1, wrreq=0. Discard beats. An accepted beat with s_last goes to TRL.
  - TRL: wrreq=~wrfull, wrdin={trunc, len[DATA_W-2:0]}. On a write:
    - pulse pkt_done on the next cycle; also pulse pkt_err if trunc;
    - seq <= seq+1, wrapping at 2^DATA_W;
    - go to SETTLE.
  - SETTLE: 2 cycles with s_ready=0 and wrreq=0, so that registered wrusedw reflects the writes. Then go to IDLE.
- Latency: first payload beat is written no earlier than 2 cycles after s_valid rises in IDLE with room available.
- A packet whose MAX_PKT-th beat carries s_last is not truncated; trailer = MAX_PKT.
- wrfull asserting mid-frame (should not occur given admission) stalls the frame in place with no loss or duplication.
- The first payload beat is the beat that triggered admission, so there are no zero-length frames.

Decomposition:
- Shared package: state enum (IDLE..SETTLE); SETTLE_CYCLES=2; trailer field positions (TRL_TRUNC_BIT = DATA_W-1, TRL_LEN_MSB = DATA_W-2); FRAME_OVERHEAD=2.
- No sub-module. Single module; the free-space compare stays inline.

Test Plan:
- Reset: hold rst_n=0 with s_valid=1 -> s_ready, wrreq, pkt_done, pkt_err, busy all 0. After release with wrusedw=0, wrfull=0 -> HDR write of 0x00 two cycles later.
- Single packet: beats 0xA1, 0xA2, 0xA3(last), wrusedw=0 -> FIFO receives 0x00, 0xA1, 0xA2, 0xA3, 0x03; pkt_done pulses once, pkt_err=0. Next packet header = 0x01.
- Admission:
  - wrusedw=500 (free 12 < 66) -> remains IDLE, s_ready=0, no wrreq.
  - Drop wrusedw to 440 (free 72) -> header written.
  - wrfull=1 with wrusedw=0 -> no admission.
- Truncation: 70-beat packet -> 64 payload words written, 6 beats accepted and discarded, trailer 0xC0, pkt_err and pkt_done pulse together.
- Stall: force wrfull=1 for 3 cycles mid-payload -> wrreq=0 and s_ready=0 during the stall; sequence resumes with no lost or repeated words. Also 64-beat packet with last on beat 64 -> trailer 0x40, pkt_err=0.
- Reset mid-payload: assert rst_n=0 after 5 beats -> wrreq drops immediately. After release the next header is 0x00 and busy=0.
